// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundles the CPU and I/O request ports, the shared single-port
//             memory drive and the busy flag of mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // I/O requester
    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_ack;
    logic [DATA_W-1:0] io_rdata;

    // Shared memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Round-robin arbiter sharing one single-port memory between a
//             CPU and an I/O requester with a fixed three-cycle transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_io;
    logic              r_win_io;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_cpu_ack;
    logic              r_io_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              r_busy;

    logic              w_any_req;
    logic              w_grant_io;
    logic              w_grant_we;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;

    // I/O wins when it is alone, or when both request and the CPU was last served.
    always_comb begin
        w_any_req     = bus.cpu_req | bus.io_req;
        w_grant_io    = bus.io_req & (~bus.cpu_req | ~r_last_io);
        w_grant_we    = w_grant_io ? bus.io_we    : bus.cpu_we;
        w_grant_addr  = w_grant_io ? bus.io_addr  : bus.cpu_addr;
        w_grant_wdata = w_grant_io ? bus.io_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last_io   <= 1'b1;
            r_win_io    <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_io_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_io_ack  <= 1'b0;
                    if (w_any_req) begin
                        r_win_io    <= w_grant_io;
                        r_last_io   <= w_grant_io;
                        r_we        <= w_grant_we;
                        r_mem_addr  <= w_grant_addr;
                        r_mem_wdata <= w_grant_wdata;
                        r_mem_we    <= w_grant_we;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= ~r_win_io;
                    r_io_ack  <= r_win_io;
                    r_state   <= ST_COMPLETE;
                end
                ST_COMPLETE: begin
                    r_cpu_ack <= 1'b0;
                    r_io_ack  <= 1'b0;
                    r_busy    <= 1'b0;
                    // Memory data for the address driven in ACCESS is valid now.
                    if (!r_we) begin
                        if (r_win_io) begin
                            r_io_rdata <= bus.mem_rdata;
                        end else begin
                            r_cpu_rdata <= bus.mem_rdata;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_io_ack  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.io_ack    = r_io_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.io_rdata  = r_io_rdata;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Transaction-level reference model and memory for mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Synchronous memory with a side port for preloading
    logic [15:0] phys [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) phys[pl_addr] <= pl_data;
        else if (bus.mem_we) phys[bus.mem_addr[9:0]] <= bus.mem_wdata;
        bus.mem_rdata <= phys[bus.mem_addr[9:0]];
    end

    // Reference model state
    logic [15:0] m_mem [0:1023];
    logic [15:0] m_cpu_rd;
    logic [15:0] m_io_rd;
    bit          m_last_io;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit io, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd);
        if (io) begin
            bus.io_req = 1'b1; bus.io_we = we; bus.io_addr = addr; bus.io_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
    endtask

    task automatic rand_req(input bit io);
        set_req(io, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), 16'($urandom));
    endtask

    task automatic model_reset();
        m_cpu_rd  = '0;
        m_io_rd   = '0;
        m_last_io = 1'b1;
    endtask

    // Serves n_txn transactions from whatever requests are currently raised.
    task automatic serve(input int n_txn, input bit refill, input bit late_io, input bit glitch);
        bit [1:0]    pend;
        bit          w;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        for (int k = 0; k < n_txn; k++) begin
            pend = {bus.io_req, bus.cpu_req};
            w    = pend[1] && (!pend[0] || !m_last_io);
            we   = w ? bus.io_we    : bus.cpu_we;
            a    = w ? bus.io_addr  : bus.cpu_addr;
            d    = w ? bus.io_wdata : bus.cpu_wdata;
            m_last_io = w;

            tick();
            chk("access_busy",  bus.busy, 1);
            chk("access_we",    bus.mem_we, we);
            chk("access_addr",  bus.mem_addr, a);
            chk("access_wdata", bus.mem_wdata, d);
            chk("access_acks",  {bus.cpu_ack, bus.io_ack}, 0);
            if (k == 0 && late_io) rand_req(1'b1);
            if (k == 0 && glitch) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end

            tick();
            chk("complete_ack",  {bus.cpu_ack, bus.io_ack}, w ? 2'b01 : 2'b10);
            chk("complete_we",   bus.mem_we, 0);
            chk("complete_busy", bus.busy, 1);
            chk("complete_addr", bus.mem_addr, a);
            if (we) m_mem[a[9:0]] = d;
            else if (w) m_io_rd = m_mem[a[9:0]];
            else m_cpu_rd = m_mem[a[9:0]];
            if (w) bus.io_req = 1'b0;
            else bus.cpu_req = 1'b0;

            tick();
            chk("idle_busy",  bus.busy, 0);
            chk("idle_acks",  {bus.cpu_ack, bus.io_ack}, 0);
            chk("idle_we",    bus.mem_we, 0);
            chk("idle_addr",  bus.mem_addr, a);
            chk("cpu_rdata",  bus.cpu_rdata, m_cpu_rd);
            chk("io_rdata",   bus.io_rdata, m_io_rd);
            if (refill && k + 2 < n_txn) rand_req(w);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.io_req  = 1'b0; bus.io_we  = 1'b0; bus.io_addr  = '0; bus.io_wdata  = '0;
        model_reset();

        // Preload memory while held in reset
        for (int i = 0; i < 1024; i++) begin
            pl_we   = 1'b1;
            pl_addr = 10'(i);
            pl_data = (i == 16) ? 16'hBEEF : 16'($urandom);
            m_mem[i] = pl_data;
            tick();
        end
        pl_we = 1'b0;

        chk("rst_cpu_ack",   bus.cpu_ack, 0);
        chk("rst_io_ack",    bus.io_ack, 0);
        chk("rst_mem_we",    bus.mem_we, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_io_rdata",  bus.io_rdata, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b1;
        tick();
        chk("idle_no_req_busy", bus.busy, 0);

        // CPU read of preloaded word
        set_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        serve(1, 0, 0, 0);
        chk("cpu_read_beef", bus.cpu_rdata, 16'hBEEF);

        // I/O write
        set_req(1'b1, 1'b1, 16'h0200, 16'h1234);
        serve(1, 0, 0, 0);
        chk("io_rdata_after_write", bus.io_rdata, 0);

        // Simultaneous requests right after reset: CPU first
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        set_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        set_req(1'b1, 1'b0, 16'h0200, 16'h0000);
        serve(2, 0, 0, 0);
        chk("both_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
        chk("both_io_rdata",  bus.io_rdata, 16'h1234);

        // I/O request raised during a CPU ACCESS is served on the next IDLE
        rand_req(1'b0);
        serve(2, 0, 1, 0);

        // Both held continuously: alternating grants, one per three cycles
        rand_req(1'b0);
        rand_req(1'b1);
        serve(8, 1, 0, 0);

        // Reset glitch between edges is ignored
        set_req(1'b1, 1'b0, 16'h0200, 16'h0000);
        serve(1, 0, 0, 1);
        chk("glitch_io_rdata", bus.io_rdata, 16'h1234);

        // Reset during the ACCESS of a CPU write aborts it
        set_req(1'b0, 1'b1, 16'h0123, 16'hA5A5);
        tick();
        chk("abort_access_we", bus.mem_we, 1);
        reset = 1'b0;
        m_mem[10'h123] = 16'hA5A5;
        tick();
        chk("abort_mem_we",   bus.mem_we, 0);
        chk("abort_busy",     bus.busy, 0);
        chk("abort_acks",     {bus.cpu_ack, bus.io_ack}, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        chk("abort_io_rdata", bus.io_rdata, 0);
        reset = 1'b1;
        model_reset();
        serve(1, 0, 0, 0);

        // Randomized mix of single and simultaneous requests
        for (int n = 0; n < 24; n++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            if (pat[0]) rand_req(1'b0);
            if (pat[1]) rand_req(1'b1);
            serve((pat == 3) ? 2 : 1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
